seg7_marquee: RTL and testbench
===============================

Name: seg7_marquee

Overview:
- Parametrised scrolling-message driver for a bank of active-low 7-segment digits.
- Slides a loadable hex message across DIGITS displays. Four modes: scroll left, scroll right, bounce (ping-pong) and hold.
- Contains its own step-rate divider, so it connects directly between the board clock and the segment pins.

Parameters:
- DIGITS, 3: number of physical digits; DIGITS >= 1.
- MSG_LEN, 3: number of message symbols, 4-bit hex each; MSG_LEN >= 1.
- DIV, 12500000: clk cycles per scroll step; DIV >= 2.
- PAD_ZERO, 1: padding symbol style. 1 shows "0" (7'b1000000); 0 shows blank (7'b1111111).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse that latches msg and restarts the sequence.
- msg  in  4*MSG_LEN  message symbols; msg[4*MSG_LEN-1 -: 4] is the first (leftmost) symbol.
- mode  in  2  00 left, 01 right, 10 bounce, 11 hold.
- en  in  1  step enable; while low, the divider and position freeze.
- seg  out  7*DIGITS  active-low segments; seg[7*DIGITS-1 -: 7] drives the leftmost digit. Bit order per digit is {g,f,e,d,c,b,a}.
- pos  out  clog2(DIGITS+MSG_LEN)  current window position k.
- step  out  1  one-cycle strobe marking the cycle in which k advanced.

Behaviour:
- Padded string:
  - P = DIGITS pad symbols, then MSG_LEN message symbols, then DIGITS-1 pad symbols.
  - Frame count F = DIGITS+MSG_LEN; valid positions are k = 0..F-1.
  - Frame k displays P[k .. k+DIGITS-1], with P[k] on the leftmost digit.
- Reset (rst=0, asynchronous):
  - Message register cleared to 0; divider = 0; k = 0; bounce direction = up.
  - step = 0; seg = all pad symbols; pos = 0.
- Divider:
  - Counts 0..DIV-1 while en=1.
  - At count DIV-1 it wraps to 0 and raises an internal tick for one cycle.
- On tick, by mode:
  - 00 (left): k <= k+1; F-1 wraps to 0.
  - 01 (right): k <= k-1; 0 wraps to F-1.
  - 10 (bounce): steps in the current direction. On reaching an endpoint (0 or F-1) the direction flips in the same cycle. Endpoint frames are shown for exactly one step, never twice.
  - 11 (hold): k unchanged; step stays 0.
- step output: asserted in the cycle k changes.
- Output latency:
  - seg and pos are registered; both reflect the new k one cycle after the tick cycle.
  - Segment decode uses the message register, never msg directly.
- load=1:
  - Latches msg; k <= 0; divider <= 0; direction <= up.
  - load has priority over a coincident tick; no step is issued that cycle.
  - seg shows frame 0 of the new message on the following cycle.
- Mode change: takes effect at the next tick. On entry to bounce, the direction register keeps its last value.
- Edge cases:
  - F = 2: bounce alternates 0,1,0,1.
  - MSG_LEN=1, DIGITS=1: F = 2.
- Hex decode: standard 0-F glyphs, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- No latches: every case branch and the default assign seg.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111 and SEG_ZERO = 7'b1000000;
  - the mode encodings MODE_LEFT, MODE_RIGHT, MODE_BOUNCE, MODE_HOLD;
  - function hex2seg(4-bit) returning the 7-bit active-low code.
- Sub-module seg7_hex_dec: combinational nibble-to-segment decode, instantiated DIGITS times via generate.
- The divider, position FSM and window selection stay in seg7_marquee.

Test Plan:
- DIGITS=3, MSG_LEN=3, DIV=4, PAD_ZERO=1, msg=12'h321, mode=00, en=1: release reset, load once. Digits step every 4 cycles through "000","003","032","321","210","100", then back to "000"; step pulses every 4 cycles.
- Same setup, mode=01: sequence runs 0, 5, 4, 3 ...; frame 5 shows "100", frame 4 shows "210"; pos wraps 0 -> 5.
- Same setup, mode=10: pos runs 0,1,2,3,4,5,4,3,2,1,0,1; endpoints appear once each.
- PAD_ZERO=0, msg=12'hAbC, mode=00: frame 1 shows blank, blank, "A" (seg = {1111111,1111111,0001000}); frame 5 shows "C", blank, blank.
- Mode=00 with pos=3, then assert load (msg=12'h789) in the same cycle as a tick: pos=0 next cycle; seg shows "000"; no step pulse; the next step occurs 4 cycles later.
- en=0 for 10 cycles mid-count, then en=1: pos and divider hold; the step resumes after the remaining count. Asserting rst=0 between clock edges immediately forces pos=0 and seg to all pad symbols.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared segment codes, mode encodings and hex glyph decode.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      4'hF:    code = 7'b0001110;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hex_dec
// Brief   : Combinational nibble to active-low 7-segment glyph.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule
`default_nettype wire

// File: rtl/seg7_marquee.sv
`default_nettype none
// ============================================================================
// Module  : seg7_marquee
// Brief   : Scrolling hex message driver for DIGITS active-low 7-seg digits.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_marquee
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int MSG_LEN  = 3,
  parameter int DIV      = 12500000,
  parameter int PAD_ZERO = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [4*MSG_LEN-1:0]                 msg,
  input  logic [1:0]                           mode,
  input  logic                                 en,
  output logic [7*DIGITS-1:0]                  seg,
  output logic [$clog2(DIGITS+MSG_LEN)-1:0]    pos,
  output logic                                 step
);

  localparam int FRAMES = DIGITS + MSG_LEN;
  localparam int PW     = $clog2(FRAMES);
  localparam int DW     = $clog2(DIV);

  localparam logic [PW-1:0] K_MAX   = PW'(FRAMES - 1);
  localparam logic [PW-1:0] K_ONE   = PW'(1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [6:0]    PAD_SEG = (PAD_ZERO != 0) ? SEG_ZERO : SEG_BLANK;

  logic [4*MSG_LEN-1:0] msg_q, msg_d;
  logic [DW-1:0]        div_q, div_d;
  logic [PW-1:0]        k_q, k_d;
  logic                 dir_up_q, dir_up_d;
  logic                 step_q, step_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d;

  logic w_tick;
  logic w_up;

  assign w_tick = en && (div_q == DIV_MAX);

  always_comb begin
    msg_d    = msg_q;
    div_d    = div_q;
    k_d      = k_q;
    dir_up_d = dir_up_q;
    step_d   = 1'b0;
    w_up     = 1'b0;
    if (en) begin
      div_d = w_tick ? '0 : div_q + DIV_ONE;
    end
    if (load) begin
      msg_d    = msg;
      div_d    = '0;
      k_d      = '0;
      dir_up_d = 1'b1;
    end else if (w_tick) begin
      case (mode_e'(mode))
        MODE_LEFT: begin
          k_d    = (k_q == K_MAX) ? '0 : k_q + K_ONE;
          step_d = 1'b1;
        end
        MODE_RIGHT: begin
          k_d    = (k_q == '0) ? K_MAX : k_q - K_ONE;
          step_d = 1'b1;
        end
        MODE_BOUNCE: begin
          // A stale direction pointing past an endpoint is turned around here.
          w_up = dir_up_q ? (k_q != K_MAX) : (k_q == '0);
          if (w_up) begin
            k_d      = k_q + K_ONE;
            dir_up_d = (k_d != K_MAX);
          end else begin
            k_d      = k_q - K_ONE;
            dir_up_d = (k_d == '0);
          end
          step_d = 1'b1;
        end
        default: begin
          k_d    = k_q;
          step_d = 1'b0;
        end
      endcase
    end
  end

  // Digit d shows padded symbol P[k+d]; decode uses next-state values so seg aligns with pos.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    int         w_idx;
    logic       w_pad;
    logic [3:0] w_nib;
    logic [6:0] w_glyph;

    always_comb begin
      w_idx = int'(k_d) + d;
      w_pad = (w_idx < DIGITS) || (w_idx >= DIGITS + MSG_LEN);
      w_nib = 4'h0;
      for (int j = 0; j < MSG_LEN; j++) begin
        if (w_idx == DIGITS + j) begin
          w_nib = msg_d[4*(MSG_LEN-1-j) +: 4];
        end
      end
    end

    seg7_hex_dec u_dec (
      .nib_i (w_nib),
      .seg_o (w_glyph)
    );

    assign seg_d[7*(DIGITS-1-d) +: 7] = w_pad ? PAD_SEG : w_glyph;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q    <= '0;
      div_q    <= '0;
      k_q      <= '0;
      dir_up_q <= 1'b1;
      step_q   <= 1'b0;
      seg_q    <= {DIGITS{PAD_SEG}};
    end else begin
      msg_q    <= msg_d;
      div_q    <= div_d;
      k_q      <= k_d;
      dir_up_q <= dir_up_d;
      step_q   <= step_d;
      seg_q    <= seg_d;
    end
  end

  assign seg  = seg_q;
  assign pos  = k_q;
  assign step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_marquee.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_marquee
// Brief   : Directed self-checking bench for seg7_marquee (DIGITS=3, MSG_LEN=3, DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_marquee;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SBb = 7'b0000011;
  localparam logic [6:0] SC  = 7'b1000110;
  localparam logic [6:0] SBL = 7'b1111111;

  logic        clk;
  logic        rst;
  logic        load, en;
  logic [11:0] msg;
  logic [1:0]  mode;
  logic [20:0] seg;
  logic [2:0]  pos;
  logic        step;

  logic        b_load, b_en;
  logic [11:0] b_msg;
  logic [1:0]  b_mode;
  logic [20:0] b_seg;
  logic [2:0]  b_pos;
  logic        b_step;

  int total = 0;
  int bad   = 0;

  seg7_marquee #(.DIGITS(3), .MSG_LEN(3), .DIV(4), .PAD_ZERO(1)) u_dut (
    .clk (clk), .rst (rst), .load (load), .msg (msg), .mode (mode), .en (en),
    .seg (seg), .pos (pos), .step (step)
  );

  seg7_marquee #(.DIGITS(3), .MSG_LEN(3), .DIV(4), .PAD_ZERO(0)) u_dut_b (
    .clk (clk), .rst (rst), .load (b_load), .msg (b_msg), .mode (b_mode), .en (b_en),
    .seg (b_seg), .pos (b_pos), .step (b_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Three quiet cycles then a step with the given frame.
  task automatic wait_step(input string tag, input logic [2:0] ep, input logic [20:0] es);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk({tag, "_quiet"}, 32'(step), 32'd0);
    end
    cyc();
    chk({tag, "_step"}, 32'(step), 32'd1);
    chk({tag, "_pos"},  32'(pos),  32'(ep));
    chk({tag, "_seg"},  32'(seg),  32'(es));
  endtask

  task automatic do_load(input logic [11:0] m, input logic [1:0] md);
    load = 1'b1; msg = m; mode = md; en = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_pos",  32'(pos),  32'd0);
    chk("load_seg",  32'(seg),  32'({S0, S0, S0}));
    chk("load_step", 32'(step), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; msg = '0; mode = 2'b00;
    b_load = 1'b0; b_en = 1'b0; b_msg = '0; b_mode = 2'b00;
    #2 rst = 1'b0;
    #1;
    chk("rst_pos",   32'(pos),   32'd0);
    chk("rst_seg",   32'(seg),   32'({S0, S0, S0}));
    chk("rst_step",  32'(step),  32'd0);
    chk("rst_seg_b", 32'(b_seg), 32'({SBL, SBL, SBL}));
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Scroll left through all frames and wrap
    do_load(12'h321, 2'b00);
    wait_step("left1", 3'd1, {S0, S0, S3});
    wait_step("left2", 3'd2, {S0, S3, S2});
    wait_step("left3", 3'd3, {S3, S2, S1});
    wait_step("left4", 3'd4, {S2, S1, S0});
    wait_step("left5", 3'd5, {S1, S0, S0});
    wait_step("left0", 3'd0, {S0, S0, S0});

    // Scroll right: 0 wraps to 5
    do_load(12'h321, 2'b01);
    wait_step("right5", 3'd5, {S1, S0, S0});
    wait_step("right4", 3'd4, {S2, S1, S0});
    wait_step("right3", 3'd3, {S3, S2, S1});

    // Bounce: endpoints shown once
    do_load(12'h321, 2'b10);
    wait_step("bnc1", 3'd1, {S0, S0, S3});
    wait_step("bnc2", 3'd2, {S0, S3, S2});
    wait_step("bnc3", 3'd3, {S3, S2, S1});
    wait_step("bnc4", 3'd4, {S2, S1, S0});
    wait_step("bnc5", 3'd5, {S1, S0, S0});
    wait_step("bnc4r", 3'd4, {S2, S1, S0});
    wait_step("bnc3r", 3'd3, {S3, S2, S1});
    wait_step("bnc2r", 3'd2, {S0, S3, S2});
    wait_step("bnc1r", 3'd1, {S0, S0, S3});
    wait_step("bnc0", 3'd0, {S0, S0, S0});
    wait_step("bnc1u", 3'd1, {S0, S0, S3});

    // Hold: no movement across a full period
    mode = 2'b11;
    for (int i = 0; i < 4; i++) cyc();
    chk("hold_pos",  32'(pos),  32'd1);
    chk("hold_step", 32'(step), 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("hold_pos2", 32'(pos),  32'd1);

    // Load coincident with a tick wins
    do_load(12'h321, 2'b00);
    wait_step("lt1", 3'd1, {S0, S0, S3});
    wait_step("lt2", 3'd2, {S0, S3, S2});
    wait_step("lt3", 3'd3, {S3, S2, S1});
    cyc(); cyc(); cyc();
    load = 1'b1; msg = 12'h789;
    cyc();
    load = 1'b0;
    chk("ltick_pos",  32'(pos),  32'd0);
    chk("ltick_seg",  32'(seg),  32'({S0, S0, S0}));
    chk("ltick_step", 32'(step), 32'd0);
    wait_step("ltick_next", 3'd1, {S0, S0, S7});

    // Freeze mid-count with en low
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frz_step", 32'(step), 32'd0);
    end
    chk("frz_pos", 32'(pos), 32'd1);
    en = 1'b1;
    cyc();
    chk("resume_quiet", 32'(step), 32'd0);
    cyc();
    chk("resume_step", 32'(step), 32'd1);
    chk("resume_pos",  32'(pos),  32'd2);
    chk("resume_seg",  32'(seg),  32'({S0, S7, S8}));

    // Blank padding instance
    en = 1'b0;
    b_load = 1'b1; b_msg = 12'hABC; b_mode = 2'b00; b_en = 1'b1;
    cyc();
    b_load = 1'b0;
    chk("blank_f0", 32'(b_seg), 32'({SBL, SBL, SBL}));
    for (int i = 0; i < 4; i++) cyc();
    chk("blank_f1_pos", 32'(b_pos), 32'd1);
    chk("blank_f1", 32'(b_seg), 32'({SBL, SBL, SA}));
    for (int i = 0; i < 4; i++) cyc();
    chk("blank_f2", 32'(b_seg), 32'({SBL, SA, SBb}));
    for (int i = 0; i < 12; i++) cyc();
    chk("blank_f5_pos", 32'(b_pos), 32'd5);
    chk("blank_f5", 32'(b_seg), 32'({SC, SBL, SBL}));

    // Asynchronous reset between edges
    en = 1'b1;
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_pos",   32'(pos),   32'd0);
    chk("arst_seg",   32'(seg),   32'({S0, S0, S0}));
    chk("arst_step",  32'(step),  32'd0);
    chk("arst_seg_b", 32'(b_seg), 32'({SBL, SBL, SBL}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
